syn_fgyrus_fft_ram_pp: RTL and testbench

//  Ping-pong, multi-channel FFT sample RAM for the fgyrus path. The PCM loader fills one

---
 rtl/syn_fgyrus_fft_ram_pp_if.sv | 51 +++++
 rtl/syn_fgyrus_fft_ram_pp.sv | 163 ++++++++++++++++
 tb/tb_syn_fgyrus_fft_ram_pp.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/syn_fgyrus_fft_ram_pp_if.sv
// Bus bundle between the PCM loader / FFT engine (master) and the ping-pong FFT sample RAM (slave).
interface syn_fgyrus_fft_ram_pp_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int NUM_CH = 2
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              pcm_wr_en;
    logic [CH_W-1:0]   pcm_wr_ch;
    logic [ADDR_W-1:0] pcm_wr_addr;
    logic [DATA_W-1:0] pcm_wr_data;
    logic              pcm_done;
    logic              fft_rd_en;
    logic [CH_W-1:0]   fft_rd_ch;
    logic [ADDR_W-1:0] fft_rd_addr;
    logic [DATA_W-1:0] fft_rd_real;
    logic [DATA_W-1:0] fft_rd_im;
    logic              fft_rd_valid;
    logic              fft_wr_real_en;
    logic              fft_wr_im_en;
    logic [CH_W-1:0]   fft_wr_ch;
    logic [ADDR_W-1:0] fft_wr_addr;
    logic [DATA_W-1:0] fft_wr_real_data;
    logic [DATA_W-1:0] fft_wr_im_data;
    logic              fft_done;
    logic              fft_start;
    logic              fft_busy;
    logic              fill_bank;
    logic              proc_bank;
    logic              overrun_err;
    logic              clr_err;

    modport master (
        output pcm_wr_en, pcm_wr_ch, pcm_wr_addr, pcm_wr_data, pcm_done,
        output fft_rd_en, fft_rd_ch, fft_rd_addr,
        output fft_wr_real_en, fft_wr_im_en, fft_wr_ch, fft_wr_addr,
        output fft_wr_real_data, fft_wr_im_data, fft_done, clr_err,
        input  fft_rd_real, fft_rd_im, fft_rd_valid,
        input  fft_start, fft_busy, fill_bank, proc_bank, overrun_err
    );

    modport slave (
        input  pcm_wr_en, pcm_wr_ch, pcm_wr_addr, pcm_wr_data, pcm_done,
        input  fft_rd_en, fft_rd_ch, fft_rd_addr,
        input  fft_wr_real_en, fft_wr_im_en, fft_wr_ch, fft_wr_addr,
        input  fft_wr_real_data, fft_wr_im_data, fft_done, clr_err,
        output fft_rd_real, fft_rd_im, fft_rd_valid,
        output fft_start, fft_busy, fill_bank, proc_bank, overrun_err
    );
endinterface

// File: rtl/syn_fgyrus_fft_ram_pp.sv
// Ping-pong multi-channel FFT sample RAM: PCM fills one bank while the FFT works in place
// on the other; bank ownership is handed over by pcm_done / fft_done.
module syn_fgyrus_fft_ram_pp #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int NUM_CH = 2
) (
    input  logic                    sys_clk_100,
    input  logic                    sys_rst,
    syn_fgyrus_fft_ram_pp_if.slave  bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NBLK  = 2 * NUM_CH;

    typedef enum logic [1:0] {BANK_FREE, BANK_READY, BANK_BUSY} bank_state_t;
    typedef enum logic {ST_IDLE, ST_RUN} proc_state_t;

    bank_state_t     bank_state_q [2];
    bank_state_t     bank_state_d [2];
    proc_state_t     proc_state_q, proc_state_d;
    logic            fill_bank_q, fill_bank_d;
    logic            proc_bank_q, proc_bank_d;
    logic            fft_start_q, fft_start_d;
    logic            fft_busy_q, fft_busy_d;
    logic            overrun_q, overrun_d;
    logic            rd_valid_q, rd_valid_d;
    logic            rd_ok_q, rd_ok_d;
    logic            rd_bank_q, rd_bank_d;
    logic [CH_W-1:0] rd_ch_q, rd_ch_d;

    always_comb begin
        bank_state_d = bank_state_q;
        proc_state_d = proc_state_q;
        fill_bank_d  = fill_bank_q;
        proc_bank_d  = proc_bank_q;
        fft_start_d  = 1'b0;
        fft_busy_d   = fft_busy_q;
        overrun_d    = overrun_q & ~bus.clr_err;

        if (proc_state_q == ST_RUN && bus.fft_done) begin
            bank_state_d[proc_bank_q] = BANK_FREE;
            fft_busy_d   = 1'b0;
            proc_state_d = ST_IDLE;
        end

        // The fill bank only accepts a hand-off while it is still FREE; otherwise PCM overran.
        if (bus.pcm_done) begin
            if (bank_state_d[fill_bank_q] == BANK_FREE)
                bank_state_d[fill_bank_q] = BANK_READY;
            else
                overrun_d = 1'b1;
        end

        // Move the PCM loader as soon as its bank holds data and the other bank is free,
        // including a bank released by fft_done in this very cycle.
        if (bank_state_d[fill_bank_q] != BANK_FREE && bank_state_d[~fill_bank_q] == BANK_FREE)
            fill_bank_d = ~fill_bank_q;

        if (proc_state_q == ST_IDLE && bank_state_d[~fill_bank_d] == BANK_READY) begin
            bank_state_d[~fill_bank_d] = BANK_BUSY;
            proc_bank_d  = ~fill_bank_d;
            fft_start_d  = 1'b1;
            fft_busy_d   = 1'b1;
            proc_state_d = ST_RUN;
        end

        rd_valid_d = bus.fft_rd_en;
        rd_ok_d    = bus.fft_rd_en & fft_busy_q & (32'(bus.fft_rd_ch) < NUM_CH);
        rd_bank_d  = proc_bank_q;
        rd_ch_d    = bus.fft_rd_ch;
    end

    always_ff @(posedge sys_clk_100 or negedge sys_rst) begin
        if (!sys_rst) begin
            bank_state_q[0] <= BANK_FREE;
            bank_state_q[1] <= BANK_FREE;
            proc_state_q    <= ST_IDLE;
            fill_bank_q     <= 1'b0;
            proc_bank_q     <= 1'b0;
            fft_start_q     <= 1'b0;
            fft_busy_q      <= 1'b0;
            overrun_q       <= 1'b0;
            rd_valid_q      <= 1'b0;
            rd_ok_q         <= 1'b0;
            rd_bank_q       <= 1'b0;
            rd_ch_q         <= '0;
        end else begin
            bank_state_q <= bank_state_d;
            proc_state_q <= proc_state_d;
            fill_bank_q  <= fill_bank_d;
            proc_bank_q  <= proc_bank_d;
            fft_start_q  <= fft_start_d;
            fft_busy_q   <= fft_busy_d;
            overrun_q    <= overrun_d;
            rd_valid_q   <= rd_valid_d;
            rd_ok_q      <= rd_ok_d;
            rd_bank_q    <= rd_bank_d;
            rd_ch_q      <= rd_ch_d;
        end
    end

    logic [DATA_W-1:0] blk_real [NBLK];
    logic [DATA_W-1:0] blk_im   [NBLK];

    // One real/imag RAM pair per (bank, channel); block gi = bank*NUM_CH + channel.
    for (genvar gi = 0; gi < NBLK; gi++) begin : g_blk
        localparam int BLK_BANK = gi / NUM_CH;
        localparam int BLK_CH   = gi % NUM_CH;

        logic [DATA_W-1:0] real_mem [DEPTH];
        logic [DATA_W-1:0] im_mem   [DEPTH];
        logic [DATA_W-1:0] rd_real_q;
        logic [DATA_W-1:0] rd_im_q;
        logic              pcm_hit;
        logic              fft_hit;
        logic              rd_hit;

        assign pcm_hit = bus.pcm_wr_en && fill_bank_q == 1'(BLK_BANK)
                         && bus.pcm_wr_ch == CH_W'(BLK_CH);
        assign fft_hit = fft_busy_q && proc_bank_q == 1'(BLK_BANK)
                         && bus.fft_wr_ch == CH_W'(BLK_CH);
        assign rd_hit  = rd_bank_q == 1'(BLK_BANK) && rd_ch_q == CH_W'(BLK_CH);

        always_ff @(posedge sys_clk_100) begin
            if (fft_hit && bus.fft_wr_real_en)
                real_mem[bus.fft_wr_addr] <= bus.fft_wr_real_data;
            else if (pcm_hit)
                real_mem[bus.pcm_wr_addr] <= bus.pcm_wr_data;
            if (fft_hit && bus.fft_wr_im_en)
                im_mem[bus.fft_wr_addr] <= bus.fft_wr_im_data;
            else if (pcm_hit)
                im_mem[bus.pcm_wr_addr] <= '0;
            if (bus.fft_rd_en) begin
                rd_real_q <= real_mem[bus.fft_rd_addr];
                rd_im_q   <= im_mem[bus.fft_rd_addr];
            end
        end

        assign blk_real[gi] = rd_hit ? rd_real_q : '0;
        assign blk_im[gi]   = rd_hit ? rd_im_q   : '0;
    end

    logic [DATA_W-1:0] rd_real_mux, rd_im_mux;

    always_comb begin
        rd_real_mux = '0;
        rd_im_mux   = '0;
        for (int i = 0; i < NBLK; i++) begin
            rd_real_mux = rd_real_mux | blk_real[i];
            rd_im_mux   = rd_im_mux   | blk_im[i];
        end
    end

    assign bus.fft_rd_real  = rd_ok_q ? rd_real_mux : '0;
    assign bus.fft_rd_im    = rd_ok_q ? rd_im_mux   : '0;
    assign bus.fft_rd_valid = rd_valid_q;
    assign bus.fft_start    = fft_start_q;
    assign bus.fft_busy     = fft_busy_q;
    assign bus.fill_bank    = fill_bank_q;
    assign bus.proc_bank    = proc_bank_q;
    assign bus.overrun_err  = overrun_q;
endmodule

// File: tb/tb_syn_fgyrus_fft_ram_pp.sv
// Directed bench for the ping-pong FFT RAM: bank hand-off, FFT in-place writes,
// overrun handling, 4-channel addressing and asynchronous reset.
module tb_syn_fgyrus_fft_ram_pp;
    logic clk;
    logic rst_n;
    int   vec_cnt;
    int   err_cnt;

    syn_fgyrus_fft_ram_pp_if #(.ADDR_W(7), .DATA_W(32), .NUM_CH(2)) ia ();
    syn_fgyrus_fft_ram_pp_if #(.ADDR_W(7), .DATA_W(32), .NUM_CH(4)) ib ();

    syn_fgyrus_fft_ram_pp #(.ADDR_W(7), .DATA_W(32), .NUM_CH(2)) u_dut_a (
        .sys_clk_100 (clk),
        .sys_rst     (rst_n),
        .bus         (ia)
    );

    syn_fgyrus_fft_ram_pp #(.ADDR_W(7), .DATA_W(32), .NUM_CH(4)) u_dut_b (
        .sys_clk_100 (clk),
        .sys_rst     (rst_n),
        .bus         (ib)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end else begin
            $display("vec %0d %s: 0x%08h ok", vec_cnt, tag, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ia.pcm_wr_en = 0; ia.pcm_wr_ch = '0; ia.pcm_wr_addr = '0; ia.pcm_wr_data = '0;
        ia.pcm_done = 0; ia.fft_rd_en = 0; ia.fft_rd_ch = '0; ia.fft_rd_addr = '0;
        ia.fft_wr_real_en = 0; ia.fft_wr_im_en = 0; ia.fft_wr_ch = '0; ia.fft_wr_addr = '0;
        ia.fft_wr_real_data = '0; ia.fft_wr_im_data = '0; ia.fft_done = 0; ia.clr_err = 0;
        ib.pcm_wr_en = 0; ib.pcm_wr_ch = '0; ib.pcm_wr_addr = '0; ib.pcm_wr_data = '0;
        ib.pcm_done = 0; ib.fft_rd_en = 0; ib.fft_rd_ch = '0; ib.fft_rd_addr = '0;
        ib.fft_wr_real_en = 0; ib.fft_wr_im_en = 0; ib.fft_wr_ch = '0; ib.fft_wr_addr = '0;
        ib.fft_wr_real_data = '0; ib.fft_wr_im_data = '0; ib.fft_done = 0; ib.clr_err = 0;
    endtask

    task automatic rd_a(input logic ch, input logic [6:0] addr);
        ia.fft_rd_en = 1; ia.fft_rd_ch = ch; ia.fft_rd_addr = addr;
        step();
        ia.fft_rd_en = 0;
    endtask

    task automatic rd_b(input logic [1:0] ch, input logic [6:0] addr);
        ib.fft_rd_en = 1; ib.fft_rd_ch = ch; ib.fft_rd_addr = addr;
        step();
        ib.fft_rd_en = 0;
    endtask

    task automatic pcm_a(input logic ch, input logic [6:0] addr, input logic [31:0] data);
        ia.pcm_wr_en = 1; ia.pcm_wr_ch = ch; ia.pcm_wr_addr = addr; ia.pcm_wr_data = data;
        step();
        ia.pcm_wr_en = 0;
    endtask

    task automatic pcm_b(input logic [1:0] ch, input logic [6:0] addr, input logic [31:0] data);
        ib.pcm_wr_en = 1; ib.pcm_wr_ch = ch; ib.pcm_wr_addr = addr; ib.pcm_wr_data = data;
        step();
        ib.pcm_wr_en = 0;
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst_n   = 1'b0;
        idle_inputs();
        repeat (3) step();

        check_vec("rst_fft_start", 32'(ia.fft_start), 32'd0);
        check_vec("rst_fft_busy", 32'(ia.fft_busy), 32'd0);
        check_vec("rst_fill_bank", 32'(ia.fill_bank), 32'd0);
        check_vec("rst_proc_bank", 32'(ia.proc_bank), 32'd0);
        check_vec("rst_overrun", 32'(ia.overrun_err), 32'd0);
        check_vec("rst_rd_valid", 32'(ia.fft_rd_valid), 32'd0);
        check_vec("rst_rd_real", ia.fft_rd_real, 32'd0);
        rst_n = 1'b1;
        step();

        // fft_done while idle must not start or disturb anything
        ia.fft_done = 1; step(); ia.fft_done = 0;
        check_vec("idle_done_busy", 32'(ia.fft_busy), 32'd0);
        check_vec("idle_done_fill", 32'(ia.fill_bank), 32'd0);

        for (int i = 0; i < 128; i++) pcm_a(1'b0, 7'(i), 32'(i));
        ia.pcm_done = 1; step(); ia.pcm_done = 0;
        check_vec("t1_fft_start", 32'(ia.fft_start), 32'd1);
        check_vec("t1_fft_busy", 32'(ia.fft_busy), 32'd1);
        check_vec("t1_proc_bank", 32'(ia.proc_bank), 32'd0);
        check_vec("t1_fill_bank", 32'(ia.fill_bank), 32'd1);
        step();
        check_vec("t1_start_pulse", 32'(ia.fft_start), 32'd0);

        rd_a(1'b0, 7'd5);
        check_vec("t1_rd_valid", 32'(ia.fft_rd_valid), 32'd1);
        check_vec("t1_rd_real5", ia.fft_rd_real, 32'd5);
        check_vec("t1_rd_im5", ia.fft_rd_im, 32'd0);
        step();
        check_vec("t1_valid_drop", 32'(ia.fft_rd_valid), 32'd0);

        ia.fft_wr_real_en = 1; ia.fft_wr_ch = 0; ia.fft_wr_addr = 7'd3;
        ia.fft_wr_real_data = 32'hAAAA5555; ia.fft_wr_im_data = 32'hFFFF;
        step(); ia.fft_wr_real_en = 0;
        rd_a(1'b0, 7'd3);
        check_vec("t2_real_only_re", ia.fft_rd_real, 32'hAAAA5555);
        check_vec("t2_real_only_im", ia.fft_rd_im, 32'd0);
        ia.fft_wr_im_en = 1; ia.fft_wr_real_data = 32'h1; ia.fft_wr_im_data = 32'h1234;
        step(); ia.fft_wr_im_en = 0;
        rd_a(1'b0, 7'd3);
        check_vec("t2_im_only_re", ia.fft_rd_real, 32'hAAAA5555);
        check_vec("t2_im_only_im", ia.fft_rd_im, 32'h1234);

        // read-first on a same-cycle read/write collision
        ia.fft_wr_real_en = 1; ia.fft_wr_addr = 7'd7; ia.fft_wr_real_data = 32'h77;
        rd_a(1'b0, 7'd7); ia.fft_wr_real_en = 0;
        check_vec("rdfirst_old", ia.fft_rd_real, 32'd7);
        rd_a(1'b0, 7'd7);
        check_vec("rdfirst_new", ia.fft_rd_real, 32'h77);

        pcm_a(1'b1, 7'd10, 32'h55);
        ia.pcm_done = 1; step(); ia.pcm_done = 0;
        check_vec("t3_second_fill", 32'(ia.fill_bank), 32'd1);
        check_vec("t3_second_ovr", 32'(ia.overrun_err), 32'd0);
        check_vec("t3_second_start", 32'(ia.fft_start), 32'd0);
        ia.pcm_done = 1; step(); ia.pcm_done = 0;
        check_vec("t3_third_ovr", 32'(ia.overrun_err), 32'd1);
        check_vec("t3_third_fill", 32'(ia.fill_bank), 32'd1);
        ia.pcm_done = 1; ia.clr_err = 1; step(); ia.pcm_done = 0; ia.clr_err = 0;
        check_vec("t3_set_wins", 32'(ia.overrun_err), 32'd1);
        ia.clr_err = 1; step(); ia.clr_err = 0;
        check_vec("t3_clr_err", 32'(ia.overrun_err), 32'd0);

        ia.fft_done = 1; step(); ia.fft_done = 0;
        check_vec("t3_done_busy", 32'(ia.fft_busy), 32'd0);
        check_vec("t3_done_fill", 32'(ia.fill_bank), 32'd0);
        step();
        check_vec("t3_b1_start", 32'(ia.fft_start), 32'd1);
        check_vec("t3_b1_proc", 32'(ia.proc_bank), 32'd1);
        rd_a(1'b1, 7'd10);
        check_vec("t3_b1_rd", ia.fft_rd_real, 32'h55);

        ia.pcm_done = 1; ia.fft_done = 1; step(); ia.pcm_done = 0; ia.fft_done = 0;
        check_vec("t4_no_overrun", 32'(ia.overrun_err), 32'd0);
        check_vec("t4_fill_toggle", 32'(ia.fill_bank), 32'd1);
        step();
        check_vec("t4_start", 32'(ia.fft_start), 32'd1);
        check_vec("t4_proc_bank", 32'(ia.proc_bank), 32'd0);

        rd_a(1'b0, 7'd9);
        check_vec("t5_pre_rst_valid", 32'(ia.fft_rd_valid), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check_vec("t5_async_busy", 32'(ia.fft_busy), 32'd0);
        check_vec("t5_async_start", 32'(ia.fft_start), 32'd0);
        check_vec("t5_async_valid", 32'(ia.fft_rd_valid), 32'd0);
        #1 rst_n = 1'b1;
        step();
        check_vec("t5_rel_fill", 32'(ia.fill_bank), 32'd0);
        ia.fft_done = 1; step(); ia.fft_done = 0;
        check_vec("t5_done_ignored", 32'(ia.fft_busy), 32'd0);

        rd_a(1'b0, 7'd5);
        check_vec("idle_rd_valid", 32'(ia.fft_rd_valid), 32'd1);
        check_vec("idle_rd_zero", ia.fft_rd_real, 32'd0);

        // FFT writes outside fft_busy are dropped
        ia.fft_wr_real_en = 1; ia.fft_wr_addr = 7'd5; ia.fft_wr_real_data = 32'hBAD;
        step(); ia.fft_wr_real_en = 0;
        ia.pcm_done = 1; step(); ia.pcm_done = 0;
        rd_a(1'b0, 7'd5);
        check_vec("idle_wr_dropped", ia.fft_rd_real, 32'd5);

        pcm_b(2'd3, 7'd127, 32'hDEAD);
        pcm_b(2'd2, 7'd127, 32'hBEEF);
        ib.pcm_done = 1; step(); ib.pcm_done = 0;
        check_vec("b_start", 32'(ib.fft_start), 32'd1);
        rd_b(2'd3, 7'd127);
        check_vec("b_ch3_rd", ib.fft_rd_real, 32'hDEAD);
        rd_b(2'd2, 7'd127);
        check_vec("b_ch2_rd", ib.fft_rd_real, 32'hBEEF);
        check_vec("b_ch2_im", ib.fft_rd_im, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
